// File: rtl/post_mac_pkg.sv
// post_mac_pkg: shared mode encoding, default widths and sum-width helper for the post-MAC stage
package post_mac_pkg;
  typedef enum logic [1:0] {
    MODE_CONV1 = 2'b00,
    MODE_CONV2 = 2'b01,
    MODE_FC    = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;
  localparam int NCH_DEF = 6;
  localparam int ACC_W_DEF = 32;
  localparam int OUT_W_DEF = 16;
  localparam int FRAC_SHIFT_DEF = 3;
  localparam int CNT_W_DEF = 16;
  // nch values plus one bias need clog2(nch+1) growth bits, plus one more for the rounding constant
  function automatic int sum_w(int acc_w, int nch);
    return acc_w + $clog2(nch + 1) + 1;
  endfunction
endpackage

// File: rtl/post_mac_lane.sv
// post_mac_lane: arithmetic right shift, optional ReLU and signed saturation of one value
module post_mac_lane #(
  parameter int IN_W = 34,
  parameter int OUT_W = 16,
  parameter int FRAC_SHIFT = 3
) (
  input  logic signed [IN_W-1:0]  val_i,
  input  logic                    relu_i,
  output logic signed [OUT_W-1:0] res_o,
  output logic                    clip_o
);
  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;
  logic signed [IN_W-1:0] shr, val;
  // shift, clamp negatives under ReLU, then clip to the signed output range
  always_comb begin
    shr = val_i >>> FRAC_SHIFT;
    val = (relu_i && shr < 0) ? '0 : shr;
    clip_o = (val > MAX_V) || (val < MIN_V);
    res_o = (val > MAX_V) ? MAX_V[OUT_W-1:0] : (val < MIN_V) ? MIN_V[OUT_W-1:0] : val[OUT_W-1:0];
  end
endmodule

// File: rtl/post_mac_pipe.sv
// post_mac_pipe: two-stage bias/sum, shift, ReLU and saturate pipeline; POST_MAC_ROUND_EN selects round-half-up
module post_mac_pipe
  import post_mac_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic                   in_last,
  input  logic [NCH*ACC_W-1:0]   mac_in,
  input  logic [NCH*ACC_W-1:0]   bias_in,
  input  logic [ACC_W-1:0]       conv2_bias,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCH*OUT_W-1:0]   out_data,
  output logic [OUT_W-1:0]       out_conv2,
  output logic [1:0]             out_mode,
  output logic                   out_last,
  output logic                   sat_flag,
  output logic [CNT_W-1:0]       sat_cnt,
  input  logic                   clr_stats
);
  localparam int LW = ACC_W + 2;
  localparam int SW = sum_w(ACC_W, NCH);
`ifdef POST_MAC_ROUND_EN
  localparam longint RND = (64'sd1 <<< FRAC_SHIFT) >>> 1;
`else
  localparam longint RND = 0;
`endif
  mode_e mode_in, s1_mode_q;
  logic s1_valid_q, s1_last_q, adv1, adv2, relu;
  logic signed [LW-1:0] lane_d [NCH];
  logic signed [LW-1:0] s1_lane_q [NCH];
  logic signed [SW-1:0] sum_d, s1_sum_q;
  logic signed [OUT_W-1:0] res [NCH+1];
  logic [NCH:0] clip;
  assign mode_in = mode_e'(in_mode);
  // handshake and S1 pre-add; values a mode does not use are forced to zero so S2 routing falls out
  always_comb begin
    adv2 = !out_valid || out_ready;
    adv1 = !s1_valid_q || adv2;
    in_ready = adv1;
    relu = (s1_mode_q == MODE_CONV1) || (s1_mode_q == MODE_CONV2);
    sum_d = (mode_in == MODE_CONV2) ? SW'($signed(conv2_bias)) + SW'(RND) : '0;
    for (int i = 0; i < NCH; i++) begin
      lane_d[i] = (mode_in == MODE_CONV2) ? '0 : LW'($signed(mac_in[i*ACC_W +: ACC_W])) + LW'(RND)
                  + ((mode_in == MODE_CONV1) ? LW'($signed(bias_in[i*ACC_W +: ACC_W])) : '0);
      sum_d = sum_d + ((mode_in == MODE_CONV2) ? SW'($signed(mac_in[i*ACC_W +: ACC_W])) : '0);
    end
  end
  // S1 register: captures an accepted beat whenever the stage can advance
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q <= MODE_CONV1;
      s1_last_q <= 1'b0;
      s1_sum_q <= '0;
      for (int i = 0; i < NCH; i++) s1_lane_q[i] <= '0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= mode_in;
        s1_last_q <= in_last;
        s1_sum_q <= sum_d;
        for (int i = 0; i < NCH; i++) s1_lane_q[i] <= lane_d[i];
      end
    end
  end
  for (genvar l = 0; l < NCH; l++) begin : g_lane
    post_mac_lane #(.IN_W(LW), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)) u_lane (
      .val_i(s1_lane_q[l]), .relu_i(relu), .res_o(res[l]), .clip_o(clip[l]));
  end
  post_mac_lane #(.IN_W(SW), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)) u_sum (
    .val_i(s1_sum_q), .relu_i(relu), .res_o(res[NCH]), .clip_o(clip[NCH]));
  // S2 register: output beat, held stable while stalled
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_conv2 <= '0;
      out_mode <= 2'b00;
      out_last <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        for (int i = 0; i < NCH; i++) out_data[i*OUT_W +: OUT_W] <= res[i];
        out_conv2 <= res[NCH];
        out_mode <= s1_mode_q;
        out_last <= s1_last_q;
      end
    end
  end
  // saturation statistics, updated as a beat enters S2; clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (!reset_n || clr_stats) begin
      sat_flag <= 1'b0;
      sat_cnt <= '0;
    end else if (adv2 && s1_valid_q) begin
      if ((|clip) || s1_mode_q == MODE_RSVD) sat_flag <= 1'b1;
      if ((|clip) && !(&sat_cnt)) sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_post_mac_pipe.sv
// tb_post_mac_pipe: directed and random checks of post_mac_pipe against an arithmetic reference model
module tb_post_mac_pipe;
  localparam int NCH = 6, ACC_W = 32, OUT_W = 16, F = 3, CNT_W = 16;
`ifdef POST_MAC_ROUND_EN
  localparam longint RND = 64'sd1 <<< (F - 1);
`else
  localparam longint RND = 0;
`endif
  typedef struct {
    logic [NCH*OUT_W-1:0] data;
    logic [OUT_W-1:0] c2;
    logic [1:0] mode;
    logic last;
    bit clip;
  } beat_t;
  logic clk = 0, reset_n, in_valid, in_ready, in_last, out_valid, out_ready, out_last, sat_flag, clr_stats;
  logic [1:0] in_mode, out_mode;
  logic [NCH*ACC_W-1:0] mac_in, bias_in;
  logic [ACC_W-1:0] conv2_bias;
  logic [NCH*OUT_W-1:0] out_data, d0;
  logic [OUT_W-1:0] out_conv2;
  logic [CNT_W-1:0] sat_cnt;
  logic stall, bp_en, bp_bit;
  beat_t exp_q[$], obs_q[$];
  int n_tests = 0, n_fail = 0, exp_cnt = 0;
  bit exp_flag = 0;
  post_mac_pipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_last(in_last), .mac_in(mac_in), .bias_in(bias_in), .conv2_bias(conv2_bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_conv2(out_conv2),
    .out_mode(out_mode), .out_last(out_last), .sat_flag(sat_flag), .sat_cnt(sat_cnt),
    .clr_stats(clr_stats));
  always #5 clk = ~clk;
  assign out_ready = !stall && (!bp_en || bp_bit);
  always @(negedge clk) bp_bit = 1'($urandom_range(0, 1));
  function automatic longint fix(longint v, bit relu, inout bit c);
    longint s;
    s = v >>> F;
    if (relu && s < 0) s = 0;
    if (s > 32767) begin c = 1; s = 32767; end
    else if (s < -32768) begin c = 1; s = -32768; end
    return s;
  endfunction
  function automatic beat_t model(logic [1:0] m, logic l, logic [NCH*ACC_W-1:0] mac, logic [NCH*ACC_W-1:0] bias, logic [ACC_W-1:0] cb);
    beat_t b;
    longint sum, mi, bi;
    bit c;
    c = 0;
    b.data = '0;
    b.c2 = '0;
    b.mode = m;
    b.last = l;
    sum = longint'($signed(cb)) + RND;
    for (int i = 0; i < NCH; i++) begin
      mi = longint'($signed(mac[i*ACC_W +: ACC_W]));
      bi = longint'($signed(bias[i*ACC_W +: ACC_W]));
      sum += mi;
      if (m == 2'b00) b.data[i*OUT_W +: OUT_W] = OUT_W'(fix(mi + bi + RND, 1, c));
      else if (m != 2'b01) b.data[i*OUT_W +: OUT_W] = OUT_W'(fix(mi + RND, 0, c));
    end
    if (m == 2'b01) b.c2 = OUT_W'(fix(sum, 1, c));
    b.clip = c;
    return b;
  endfunction
  function automatic logic [NCH*ACC_W-1:0] pk(int a0, int a1, int a2, int a3, int a4, int a5);
    int a[NCH];
    logic [NCH*ACC_W-1:0] r;
    a = '{a0, a1, a2, a3, a4, a5};
    for (int i = 0; i < NCH; i++) r[i*ACC_W +: ACC_W] = a[i];
    return r;
  endfunction
  function automatic logic [31:0] rv();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'(int'($urandom_range(0, 8000)) - 4000);
  endfunction
  // record accepted beats (through the model) and emitted beats
  always @(posedge clk) begin
    beat_t b, o;
    if (reset_n && in_valid && in_ready) begin
      b = model(in_mode, in_last, mac_in, bias_in, conv2_bias);
      exp_q.push_back(b);
      if (b.clip || b.mode == 2'b11) exp_flag = 1;
      if (b.clip && exp_cnt < 65535) exp_cnt++;
    end
    if (reset_n && out_valid && out_ready) begin
      o.data = out_data;
      o.c2 = out_conv2;
      o.mode = out_mode;
      o.last = out_last;
      o.clip = 0;
      obs_q.push_back(o);
    end
  end
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic send(logic [1:0] m, logic l, logic [NCH*ACC_W-1:0] mac, logic [NCH*ACC_W-1:0] bias, logic [ACC_W-1:0] cb);
    int t = 0;
    @(negedge clk);
    in_valid = 1; in_mode = m; in_last = l; mac_in = mac; bias_in = bias; conv2_bias = cb;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("send_timeout", 128'(in_ready), 128'd1);
    @(posedge clk);
  endtask
  task automatic drain();
    int t = 0;
    beat_t e, o;
    @(negedge clk);
    in_valid = 0;
    stall = 0;
    while (!(exp_q.size() == obs_q.size() && !out_valid) && t < 400) begin @(negedge clk); t++; end
    chk("drain_count", 128'(obs_q.size()), 128'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk("beat_data", 128'(o.data), 128'(e.data));
      chk("beat_conv2", 128'(o.c2), 128'(e.c2));
      chk("beat_mode", 128'(o.mode), 128'(e.mode));
      chk("beat_last", 128'(o.last), 128'(e.last));
    end
    exp_q.delete();
    obs_q.delete();
  endtask
  initial begin
    reset_n = 0; in_valid = 0; in_mode = 0; in_last = 0; mac_in = '0; bias_in = '0; conv2_bias = '0;
    clr_stats = 0; stall = 0; bp_en = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", 128'(out_data), 128'd0);
    chk("rst_sat_cnt", 128'(sat_cnt), 128'd0);
    chk("rst_sat_flag", 128'(sat_flag), 128'd0);
    reset_n = 1;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    send(2'b00, 0, pk(100, -50, 0, 0, 0, 0), pk(4, 10, 0, 0, 0, 0), 0);
    @(negedge clk);
    in_valid = 0;
    chk("t1_lat1_valid", 128'(out_valid), 128'd0);
    @(negedge clk);
    chk("t1_lat2_valid", 128'(out_valid), 128'd1);
    chk("t1_lane0", 128'(out_data[15:0]), 128'd13);
    chk("t1_lane1", 128'(out_data[31:16]), 128'd0);
    chk("t1_conv2", 128'(out_conv2), 128'd0);
    drain();
    send(2'b01, 0, pk(8, 8, 8, 8, 8, 8), pk(1, 2, 3, 4, 5, 6), 16);
    drain();
    chk("t2_conv2", 128'(out_conv2), 128'd8);
    chk("t2_data", 128'(out_data), 128'd0);
    chk("t2_mode", 128'(out_mode), 128'd1);
    send(2'b10, 0, pk(-24, 1048576, -1073741824, 0, 0, 0), pk(5, 5, 5, 5, 5, 5), 7);
    drain();
    chk("t3_lane0", 128'(out_data[15:0]), 128'hFFFD);
    chk("t3_lane1", 128'(out_data[31:16]), 128'h7FFF);
    chk("t3_lane2", 128'(out_data[47:32]), 128'h8000);
    chk("t3_sat_cnt", 128'(sat_cnt), 128'd1);
    chk("t3_sat_flag", 128'(sat_flag), 128'd1);
    chk("t3_cnt_model", 128'(sat_cnt), 128'(exp_cnt));
    @(negedge clk); clr_stats = 1;
    @(negedge clk); clr_stats = 0;
    exp_cnt = 0; exp_flag = 0;
    chk("t3_clr_cnt", 128'(sat_cnt), 128'd0);
    chk("t3_clr_flag", 128'(sat_flag), 128'd0);
    send(2'b10, 0, pk(1048576, 0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0, 0), 0);
    @(negedge clk); in_valid = 0; clr_stats = 1;
    @(negedge clk); clr_stats = 0;
    exp_cnt = 0; exp_flag = 0;
    chk("clr_wins_cnt", 128'(sat_cnt), 128'd0);
    chk("clr_wins_flag", 128'(sat_flag), 128'd0);
    drain();
    send(2'b10, 0, pk(12, -12, 0, 0, 0, 0), pk(3, 3, 3, 3, 3, 3), 0);
    drain();
`ifdef POST_MAC_ROUND_EN
    chk("t6_lane0", 128'(out_data[15:0]), 128'd2);
    chk("t6_lane1", 128'(out_data[31:16]), 128'hFFFF);
`else
    chk("t6_lane0", 128'(out_data[15:0]), 128'd1);
    chk("t6_lane1", 128'(out_data[31:16]), 128'hFFFE);
`endif
    stall = 1;
    send(2'b00, 0, pk(800, -8, 16, 0, 0, 0), pk(8, 0, 0, 0, 0, 0), 0);
    send(2'b01, 0, pk(40, 40, 0, 0, 0, 0), pk(0, 0, 0, 0, 0, 0), -8);
    @(negedge clk);
    in_valid = 0;
    chk("t4_in_ready_full", 128'(in_ready), 128'd0);
    chk("t4_out_valid", 128'(out_valid), 128'd1);
    d0 = out_data;
    @(negedge clk);
    chk("t4_stable_data", 128'(out_data), 128'(d0));
    chk("t4_stable_mode", 128'(out_mode), 128'd0);
    chk("t4_in_ready_hold", 128'(in_ready), 128'd0);
    stall = 0;
    send(2'b10, 0, pk(-64, 64, 0, 0, 0, 0), pk(9, 9, 9, 9, 9, 9), 0);
    send(2'b00, 1, pk(-800, 800, 0, 0, 0, 0), pk(0, 0, 0, 0, 0, 0), 0);
    drain();
    chk("t4_last_on_b4", 128'(out_last), 128'd1);
    @(negedge clk); clr_stats = 1;
    @(negedge clk); clr_stats = 0;
    exp_cnt = 0; exp_flag = 0;
    stall = 1;
    send(2'b10, 0, pk(1048576, 0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0, 0), 0);
    send(2'b10, 0, pk(-1048576, 0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0, 0), 0);
    @(negedge clk);
    in_valid = 0;
    chk("t5_pre_cnt", 128'(sat_cnt), 128'd1);
    chk("t5_pre_valid", 128'(out_valid), 128'd1);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    stall = 0;
    chk("t5_out_valid", 128'(out_valid), 128'd0);
    chk("t5_sat_cnt", 128'(sat_cnt), 128'd0);
    chk("t5_sat_flag", 128'(sat_flag), 128'd0);
    chk("t5_in_ready", 128'(in_ready), 128'd1);
    exp_q.delete(); obs_q.delete();
    exp_cnt = 0; exp_flag = 0;
    repeat (3) @(negedge clk);
    chk("t5_idle_valid", 128'(out_valid), 128'd0);
    chk("t5_idle_obs", 128'(obs_q.size()), 128'd0);
    bp_en = 1;
    for (int n = 0; n < 80; n++) begin
      logic [NCH*ACC_W-1:0] m, b;
      for (int i = 0; i < NCH; i++) begin
        m[i*ACC_W +: ACC_W] = rv();
        b[i*ACC_W +: ACC_W] = rv();
      end
      send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), m, b, rv());
    end
    drain();
    bp_en = 0;
    chk("rand_sat_cnt", 128'(sat_cnt), 128'(exp_cnt));
    chk("rand_sat_flag", 128'(sat_flag), 128'(exp_flag));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
